instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_if.sv | 36 +++
 rtl/instr_encoder.sv | 106 ++++++++++
 tb/tb_instr_encoder.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Request/response bundle between an instruction source and the MIPS encoder.
// Request side: in_valid/in_ready handshake with the mnemonic select and raw fields.
// Response side: out_valid/out_ready handshake carrying the encoded word and its address.
interface instr_encoder_if #(
    parameter int ADDR_WIDTH = 6
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            in_sel;
    logic [4:0]            in_rs;
    logic [4:0]            in_rt;
    logic [4:0]            in_rd;
    logic [4:0]            in_shamt;
    logic [5:0]            in_funct;
    logic [15:0]           in_imm;
    logic [25:0]           in_target;

    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_instr;
    logic [ADDR_WIDTH-1:0] out_addr;

    // Encoder side
    modport slave (
        input  in_valid, in_sel, in_rs, in_rt, in_rd, in_shamt,
               in_funct, in_imm, in_target, out_ready,
        output in_ready, out_valid, out_instr, out_addr
    );

    // Source / memory-writer side
    modport master (
        output in_valid, in_sel, in_rs, in_rt, in_rd, in_shamt,
               in_funct, in_imm, in_target, out_ready,
        input  in_ready, out_valid, out_instr, out_addr
    );
endinterface

// File: rtl/instr_encoder.sv
// Encodes mnemonic select plus fields into a 32-bit MIPS word with a running word address.
// Latency: one cycle from accept to out_valid; one-entry output register, no bubble.
// Backpressure: in_ready = !out_valid || out_ready; word/address held while stalled.
//
// Ports: clk, reset (sync, active-high); bus (slave modport: request and response
// channels); err_invalid (sticky, an invalid select was accepted); word_count
// (saturating count of transferred words).
module instr_encoder #(
    parameter int ADDR_WIDTH = 6,
    parameter int BASE_ADDR  = 0
) (
    input  logic                clk,
    input  logic                reset,
    instr_encoder_if.slave      bus,
    output logic                err_invalid,
    output logic [ADDR_WIDTH:0] word_count
);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    logic                  out_valid_q, out_valid_d;
    logic [31:0]           out_instr_q, out_instr_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic                  err_q,       err_d;
    logic [ADDR_WIDTH:0]   count_q,     count_d;

    logic        enc_vld;
    logic [31:0] enc_word;
    logic        accept;
    logic        xfer;

    assign bus.in_ready  = ~out_valid_q | bus.out_ready;
    assign accept        = bus.in_valid & bus.in_ready;
    assign xfer          = out_valid_q & bus.out_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_addr  = addr_q;
    assign err_invalid   = err_q;
    assign word_count    = count_q;

    // Field packing per mnemonic; selects 10-15 flag enc_vld low.
    always_comb begin
        enc_vld  = 1'b1;
        enc_word = 32'h0;
        case (bus.in_sel)
            4'd0: enc_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_funct};
            4'd1: enc_word = {6'h08, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd2: enc_word = {6'h0D, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd3: enc_word = {6'h0F, 5'd0,      bus.in_rt, bus.in_imm}; // LUI has no source register
            4'd4: enc_word = {6'h0C, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd5: enc_word = {6'h04, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd6: enc_word = {6'h05, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd7: enc_word = {6'h23, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd8: enc_word = {6'h2B, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd9: enc_word = {6'h02, bus.in_target};
            default: begin
                enc_vld  = 1'b0;
                enc_word = 32'h0;
            end
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        addr_d      = addr_q;
        err_d       = err_q;
        count_d     = count_q;

        // A transfer retires the current word and advances the address.
        if (xfer) begin
            out_valid_d = 1'b0;
            addr_d      = addr_q + 1'b1;
            if (count_q != '1) begin
                count_d = count_q + 1'b1;
            end
        end

        // An accept can only happen with the register empty or draining this cycle,
        // so installing a new word here never overwrites an untransferred one.
        if (accept) begin
            if (enc_vld) begin
                out_valid_d = 1'b1;
                out_instr_d = enc_word;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0;
            addr_q      <= BASE;
            err_q       <= 1'b0;
            count_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
            count_q     <= count_d;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
// Uses ADDR_WIDTH=2 so address wrap and word_count saturation are reachable.
module tb_instr_encoder;
    localparam int AW   = 2;
    localparam int BASE = 0;
    localparam int MAXC = (1 << (AW + 1)) - 1;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          err_invalid;
    logic [AW:0]   word_count;

    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_WIDTH(AW)) bus ();

    instr_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .err_invalid (err_invalid),
        .word_count  (word_count)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    // Reference encoding from the opcode table.
    function automatic logic [31:0] ref_enc(input int sel, input int rs, input int rt,
                                            input int rd, input int sh, input int fn,
                                            input int imm, input int tgt);
        int op_tab [10] = '{'h00, 'h08, 'h0D, 'h0F, 'h0C, 'h04, 'h05, 'h23, 'h2B, 'h02};
        int w;
        if (sel == 0)
            w = (rs << 21) | (rt << 16) | (rd << 11) | (sh << 6) | fn;
        else if (sel == 9)
            w = (op_tab[9] << 26) | tgt;
        else
            w = (op_tab[sel] << 26) | (((sel == 3) ? 0 : rs) << 21) | (rt << 16) | imm;
        return 32'(w);
    endfunction

    // Behavioural model state
    bit          m_vld   = 0;
    logic [31:0] m_instr = 0;
    int          m_addr  = BASE;
    bit          m_err   = 0;
    int          m_cnt   = 0;
    bit          chk_en  = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_vld   <= 0;
            m_instr <= 0;
            m_addr  <= BASE;
            m_err   <= 0;
            m_cnt   <= 0;
            chk_en  <= 1;
        end else begin
            if (m_vld && bus.out_ready) begin
                m_addr <= (m_addr + 1) % (1 << AW);
                m_cnt  <= (m_cnt == MAXC) ? MAXC : m_cnt + 1;
            end
            if (bus.in_valid && (!m_vld || bus.out_ready)) begin
                if (int'(bus.in_sel) <= 9) begin
                    m_vld   <= 1;
                    m_instr <= ref_enc(bus.in_sel, bus.in_rs, bus.in_rt, bus.in_rd,
                                       bus.in_shamt, bus.in_funct, bus.in_imm, bus.in_target);
                end else begin
                    m_err <= 1;
                    m_vld <= 0;
                end
            end else if (m_vld && bus.out_ready) begin
                m_vld <= 0;
            end
        end
    end

    // Per-cycle comparison: registered outputs at the falling edge, in_ready just before rise.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid",   32'(bus.out_valid), 32'(m_vld));
            if (m_vld) chk("out_instr", bus.out_instr, m_instr);
            chk("out_addr",    32'(bus.out_addr),  32'(m_addr));
            chk("err_invalid", 32'(err_invalid),   32'(m_err));
            chk("word_count",  32'(word_count),    32'(m_cnt));
            #4;
            chk("in_ready",    32'(bus.in_ready),  32'(!m_vld || bus.out_ready));
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic req(input int sel, input int rs, input int rt, input int rd,
                       input int sh, input int fn, input int imm, input int tgt);
        bus.in_valid  = 1'b1;
        bus.in_sel    = 4'(sel);
        bus.in_rs     = 5'(rs);
        bus.in_rt     = 5'(rt);
        bus.in_rd     = 5'(rd);
        bus.in_shamt  = 5'(sh);
        bus.in_funct  = 6'(fn);
        bus.in_imm    = 16'(imm);
        bus.in_target = 26'(tgt);
    endtask

    task automatic rst_pulse();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int exp_addr [5] = '{0, 1, 2, 3, 0};

        req(0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        bus.out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Post-reset state
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_addr",  32'(bus.out_addr),  BASE);
        chk("rst_err",       32'(err_invalid),   0);
        chk("rst_count",     32'(word_count),    0);
        chk("rst_in_ready",  32'(bus.in_ready),  1);

        // ADDI, one-cycle latency
        req(1, 1, 2, 0, 0, 0, 'h0005, 0);
        tick();
        idle();
        chk("addi_valid", 32'(bus.out_valid), 1);
        chk("addi_instr", bus.out_instr, 32'h20220005);
        chk("addi_addr",  32'(bus.out_addr), 0);
        tick();
        chk("addi_count", 32'(word_count), 1);

        // R-type held under backpressure
        bus.out_ready = 1'b0;
        req(0, 1, 2, 3, 0, 'h20, 0, 0);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            chk("r_hold_instr", bus.out_instr, 32'h00221820);
            chk("r_hold_rdy",   32'(bus.in_ready), 0);
            chk("r_hold_addr",  32'(bus.out_addr), 1);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        chk("r_count", 32'(word_count), 2);

        // LW then J back-to-back
        rst_pulse();
        req(7, 29, 8, 0, 0, 0, 4, 0);
        tick();
        chk("lw_instr", bus.out_instr, 32'h8FA80004);
        chk("lw_addr",  32'(bus.out_addr), 0);
        req(9, 0, 0, 0, 0, 0, 0, 'h0100000);
        tick();
        idle();
        chk("j_valid", 32'(bus.out_valid), 1);
        chk("j_instr", bus.out_instr, 32'h08100000);
        chk("j_addr",  32'(bus.out_addr), 1);
        tick();

        // Invalid select followed by LUI
        rst_pulse();
        req(12, 3, 3, 3, 3, 3, 3, 3);
        tick();
        chk("inv_err",   32'(err_invalid),   1);
        chk("inv_valid", 32'(bus.out_valid), 0);
        req(3, 7, 1, 0, 0, 0, 'h1001, 0);
        tick();
        idle();
        chk("lui_instr", bus.out_instr, 32'h3C011001);
        chk("lui_addr",  32'(bus.out_addr), 0);
        tick();
        chk("lui_err_sticky", 32'(err_invalid), 1);

        // Address wrap over five transfers, then count saturation
        rst_pulse();
        for (int i = 0; i < 5; i++) begin
            req(1, i, i, 0, 0, 0, i, 0);
            tick();
            chk("wrap_addr", 32'(bus.out_addr), exp_addr[i]);
        end
        idle();
        tick();
        chk("wrap_count", 32'(word_count), 5);
        for (int i = 0; i < 4; i++) begin
            req(2, 1, 1, 0, 0, 0, i, 0);
            tick();
        end
        idle();
        tick();
        chk("sat_count", 32'(word_count), MAXC);

        // Reset discards a stalled word and clears the sticky error
        rst_pulse();
        bus.out_ready = 1'b0;
        req(13, 0, 0, 0, 0, 0, 0, 0);
        tick();
        req(1, 4, 5, 0, 0, 0, 'h00FF, 0);
        tick();
        idle();
        chk("pend_valid", 32'(bus.out_valid), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_valid", 32'(bus.out_valid), 0);
        chk("rst2_addr",  32'(bus.out_addr),  BASE);
        chk("rst2_err",   32'(err_invalid),   0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 63) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0)
                req($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
                    $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 63),
                    $urandom_range(0, 65535), $urandom_range(0, (1 << 26) - 1));
            else
                idle();
            tick();
        end
        reset = 1'b0;
        idle();
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
